// File: rtl/alex_relay_sequencer.sv
// Alex relay word serialiser: sends the 24-bit relay frame over 3-wire SPI on change,
// on periodic refresh, or after reset, and grants tx_ready once a PTT frame has settled.
module alex_relay_sequencer #(
    parameter int SCK_DIV      = 4,
    parameter int RELAY_SETTLE = 2000,
    parameter int REFRESH      = 1 << 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] hpf,
    input  logic [6:0] lpf,
    input  logic [1:0] ant,
    input  logic [1:0] atten,
    input  logic       ptt,
    output logic       spi_sck,
    output logic       spi_data,
    output logic       spi_load,
    output logic       busy,
    output logic       tx_ready
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, SETTLE} state_t;

    localparam logic [31:0] DIV_LAST = 32'(SCK_DIV - 1);
    localparam logic [31:0] SET_LAST = 32'(RELAY_SETTLE - 1);
    localparam logic [31:0] REF_LAST = (REFRESH == 0) ? 32'd0 : 32'(REFRESH - 1);

    state_t      state;
    logic [23:0] live, shadow, shreg;
    logic        force_send, ref_hit;
    logic [31:0] ref_cnt, div_cnt, set_cnt;
    logic [4:0]  bit_cnt;

    assign live    = {6'b0, ptt, atten, ant, lpf, hpf};
    assign ref_hit = (REFRESH != 0) && (ref_cnt == REF_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            spi_sck    <= 1'b0;
            spi_data   <= 1'b0;
            spi_load   <= 1'b0;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
            force_send <= 1'b1;
            ref_cnt    <= '0;
            div_cnt    <= '0;
            set_cnt    <= '0;
            bit_cnt    <= '0;
            shadow     <= '0;
            shreg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // tx_ready drops together with busy rising so the relays never move while keyed
                    if (live != shadow || force_send || ref_hit) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                    end else if (REFRESH != 0) begin
                        ref_cnt <= ref_cnt + 32'd1;
                    end
                end
                LOAD: begin
                    shreg      <= live;
                    shadow     <= live;
                    spi_data   <= live[23];
                    force_send <= 1'b0;
                    ref_cnt    <= '0;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 5'd23) begin
                                state    <= LATCH;
                                spi_load <= 1'b1;
                            end else begin
                                bit_cnt  <= bit_cnt + 5'd1;
                                shreg    <= {shreg[22:0], 1'b0};
                                spi_data <= shreg[22];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_load <= 1'b0;
                        set_cnt  <= '0;
                        state    <= SETTLE;
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= shadow[17] && ptt;
                    end else begin
                        set_cnt <= set_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Unkeying always wins, whatever the sequencer is doing
            if (!ptt) tx_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alex_relay_sequencer.sv
// Scoreboard bench: expected frames are queued when inputs are driven and
// compared when the SPI monitor sees the latch strobe.
module tb_alex_relay_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] hpf;
    logic [6:0] lpf;
    logic [1:0] ant, atten;
    logic       ptt;
    logic       spi_sck, spi_data, spi_load, busy, tx_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [23:0] sbq[$];

    int          bitcnt = 0;
    int          ldw    = 0;
    int          txr_viol = 0;
    logic [23:0] sh = '0;
    logic        prev_sck = 1'b0, prev_ld = 1'b0;

    alex_relay_sequencer #(.SCK_DIV(2), .RELAY_SETTLE(10), .REFRESH(200)) dut (
        .clock(clock), .reset(reset), .hpf(hpf), .lpf(lpf), .ant(ant), .atten(atten),
        .ptt(ptt), .spi_sck(spi_sck), .spi_data(spi_data), .spi_load(spi_load),
        .busy(busy), .tx_ready(tx_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] fr();
        return {6'b0, ptt, atten, ant, lpf, hpf};
    endfunction

    // SPI receiver: data sampled at each SCK rise, frame closed on the latch strobe
    always @(negedge clock) begin
        if (reset) begin
            bitcnt = 0; ldw = 0; prev_sck = 1'b0; prev_ld = 1'b0;
        end else begin
            if (spi_sck && !prev_sck) begin
                sh = {sh[22:0], spi_data};
                bitcnt++;
            end
            if (spi_load) ldw++;
            if (spi_load && !prev_ld) begin
                chk("bits", bitcnt, 24);
                if (sbq.size() == 0) chk("sb_underflow", 32'(sbq.size()), 1);
                else chk("frame", sh, sbq.pop_front());
                bitcnt = 0;
            end
            if (!spi_load && prev_ld) begin
                chk("load_w", ldw, 2);
                ldw = 0;
            end
            if (busy && tx_ready) txr_viol++;
            prev_sck = spi_sck;
            prev_ld  = spi_load;
        end
    end

    task automatic wait_busy(input logic lvl, input string tag, output int at);
        int n = 0;
        while (busy !== lvl && n < 3000) begin
            @(negedge clock); #1;
            n++;
        end
        chk(tag, busy, lvl);
        at = cyc;
    endtask

    task automatic wait_bits(input int b);
        int n = 0;
        while (bitcnt < b && n < 500) begin
            @(negedge clock); #1;
            n++;
        end
        chk("bits_reached", bitcnt >= b, 1);
    endtask

    initial begin
        int r1, f1, r2, f2, ra, fa, n;
        reset = 1'b1; hpf = 6'b010000; lpf = 7'h04; ant = 2'd1; atten = 2'd0; ptt = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_out", {spi_sck, spi_data, spi_load, busy, tx_ready}, 0);

        // T1: frame after reset, latency and busy duration
        sbq.push_back(fr());
        reset = 1'b0;
        wait_busy(1, "t1_rise", r1);
        n = 0;
        while (!spi_sck && n < 50) begin @(negedge clock); #1; n++; end
        chk("t1_lat", cyc - r1, 3);
        wait_busy(0, "t1_fall", f1);
        chk("t1_dur", f1 - r1, 109);
        chk("t1_txr", tx_ready, 0);

        // T2: refresh of identical frame
        sbq.push_back(fr());
        wait_busy(1, "t2_rise", r2);
        chk("t2_period", r2 - r1, 309);
        wait_busy(0, "t2_fall", f2);
        chk("t2_txr", tx_ready, 0);

        // T3: key and unkey
        ptt = 1'b1;
        sbq.push_back(fr());
        wait_busy(1, "t3_rise", ra);
        chk("t3_txr_load", tx_ready, 0);
        wait_busy(0, "t3_fall", fa);
        chk("t3_txr_exit", tx_ready, 1);
        @(negedge clock); #1;
        ptt = 1'b0;
        sbq.push_back(fr());
        @(negedge clock); #1;
        chk("t3_txr_drop", tx_ready, 0);
        chk("t3_busy", busy, 1);
        wait_busy(0, "t3_fall2", fa);

        // T4: band change while keyed
        ptt = 1'b1;
        sbq.push_back(fr());
        wait_busy(1, "t4_rise", ra);
        wait_busy(0, "t4_fall", fa);
        chk("t4_txr_ready", tx_ready, 1);
        hpf = 6'b000001;
        sbq.push_back(fr());
        wait_busy(1, "t4_rise2", ra);
        chk("t4_txr_load", tx_ready, 0);
        wait_busy(0, "t4_fall2", fa);
        chk("t4_txr_reready", tx_ready, 1);

        // T5: lpf change mid-frame queues exactly one follow-up frame
        ptt = 1'b0;
        sbq.push_back(fr());
        wait_busy(1, "t5_rise0", ra);
        wait_busy(0, "t5_fall0", fa);
        lpf = 7'h10;
        sbq.push_back(fr());
        wait_busy(1, "t5_rise", ra);
        wait_bits(10);
        lpf = 7'h20;
        sbq.push_back(fr());
        wait_busy(0, "t5_fall", fa);
        wait_busy(1, "t5_rise2", ra);
        chk("t5_gap", ra - fa, 1);
        wait_busy(0, "t5_fall2", fa);

        // T6: reset during shift; the same frame is resent from scratch
        atten = 2'd2;
        sbq.push_back(fr());
        wait_busy(1, "t6_rise", ra);
        wait_bits(5);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("t6_rst_out", {spi_sck, spi_data, spi_load, busy, tx_ready}, 0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        wait_busy(1, "t6_rise2", ra);
        wait_busy(0, "t6_fall2", fa);

        repeat (20) @(negedge clock);
        chk("sb_drain", sbq.size(), 0);
        chk("txr_while_busy", txr_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
